// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of a single-port SDRAM controller: fixed SPI priority,
// one transaction per grant, no-ack watchdog. Optional starvation guard: ARB_STARVE_GUARD_EN.
module sdram_port_arbiter #(
  parameter int ADDR_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic [7:0]           spi_wr_data,
  input  logic                 spi_we,
  input  logic                 spi_enable,
  output logic [7:0]           spi_rd_data,
  output logic                 spi_ack,
  output logic                 spi_idle,
  input  logic [ADDR_BITS-1:0] user_addr,
  input  logic [7:0]           user_wr_data,
  input  logic                 user_we,
  input  logic                 user_enable,
  output logic [7:0]           user_rd_data,
  output logic                 user_ack,
  output logic                 user_idle,
  output logic [ADDR_BITS-1:0] sd_addr,
  output logic [7:0]           sd_wr_data,
  output logic                 sd_we,
  output logic                 sd_enable,
  input  logic [7:0]           sd_rd_data,
  input  logic                 sd_ack,
  input  logic                 sd_idle,
  output logic                 timeout_err
);

  // state     | meaning
  // IDLE      | no grant; arbitrate when sd_idle
  // BUSY_SPI  | SPI owns the controller, waiting for sd_ack
  // BUSY_USER | user owns the controller, waiting for sd_ack
  // RELEASE   | wait for owner enable low and sd_idle before re-arbitrating
  typedef enum logic [1:0] {IDLE, BUSY_SPI, BUSY_USER, RELEASE} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   sd_addr_q, sd_addr_d;
  logic [7:0]             sd_wr_data_q, sd_wr_data_d;
  logic                   sd_we_q, sd_we_d;
  logic                   sd_enable_q, sd_enable_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
  logic                   owner_user_q, owner_user_d;

  logic can_grant, grant_spi, grant_user, starved, owner_en;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign starved = (starve_cnt_q == 8'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_user)
      starve_cnt_d = 8'd0;
    else if (grant_spi)
      starve_cnt_d = user_enable ? starve_cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_cnt_q <= 8'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starved = 1'b0;
`endif

  assign can_grant  = (state_q == IDLE) && sd_idle;
  assign grant_user = can_grant && user_enable && (!spi_enable || starved);
  assign grant_spi  = can_grant && spi_enable && !grant_user;
  assign owner_en   = owner_user_q ? user_enable : spi_enable;

  always_comb begin
    state_d       = state_q;
    sd_addr_d     = sd_addr_q;
    sd_wr_data_d  = sd_wr_data_q;
    sd_we_d       = sd_we_q;
    sd_enable_d   = sd_enable_q;
    timeout_err_d = 1'b0;
    wd_cnt_d      = wd_cnt_q;
    owner_user_d  = owner_user_q;
    case (state_q)
      IDLE: begin
        if (grant_spi) begin
          sd_addr_d    = spi_addr;
          sd_wr_data_d = spi_wr_data;
          sd_we_d      = spi_we;
          sd_enable_d  = 1'b1;
          wd_cnt_d     = '0;
          owner_user_d = 1'b0;
          state_d      = BUSY_SPI;
        end else if (grant_user) begin
          sd_addr_d    = user_addr;
          sd_wr_data_d = user_wr_data;
          sd_we_d      = user_we;
          sd_enable_d  = 1'b1;
          wd_cnt_d     = '0;
          owner_user_d = 1'b1;
          state_d      = BUSY_USER;
        end
      end
      BUSY_SPI, BUSY_USER: begin
        if (sd_ack) begin
          sd_enable_d = 1'b0;
          sd_we_d     = 1'b0;
          state_d     = RELEASE;
        end else if (wd_cnt_q == WD_LAST) begin
          // Abort without acking the owner; it sees only the error pulse.
          timeout_err_d = 1'b1;
          sd_enable_d   = 1'b0;
          sd_we_d       = 1'b0;
          state_d       = RELEASE;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!owner_en && sd_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sd_addr_q     <= '0;
      sd_wr_data_q  <= 8'd0;
      sd_we_q       <= 1'b0;
      sd_enable_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
      owner_user_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      sd_addr_q     <= sd_addr_d;
      sd_wr_data_q  <= sd_wr_data_d;
      sd_we_q       <= sd_we_d;
      sd_enable_q   <= sd_enable_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
      owner_user_q  <= owner_user_d;
    end
  end

  assign sd_addr      = sd_addr_q;
  assign sd_wr_data   = sd_wr_data_q;
  assign sd_we        = sd_we_q;
  assign sd_enable    = sd_enable_q;
  assign timeout_err  = timeout_err_q;
  assign spi_rd_data  = sd_rd_data;
  assign user_rd_data = sd_rd_data;
  assign spi_ack      = (state_q == BUSY_SPI) && sd_ack;
  assign user_ack     = (state_q == BUSY_USER) && sd_ack;
  assign spi_idle     = can_grant;
  assign user_idle    = can_grant && (!spi_enable || starved);

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-port SDRAM controller interface between two requesters.
  - Requester 0: the SPI flash emulator, latency-critical.
  - Requester 1: the serial user command parser, bulk read/write.
- Both requesters use the same enable/we/ack/idle protocol, so each sees the arbiter as a private SDRAM port.
- Fixed priority to SPI, one transaction per grant, plus a no-ack watchdog.

Parameters:
- ADDR_BITS, 32, width of all address buses.
- TIMEOUT_CYCLES, 1024, cycles without sd_ack after issue before the grant is aborted.
- STARVE_LIMIT, 8, consecutive SPI grants allowed while user is pending (only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- spi_addr  in  ADDR_BITS  SPI request address.
- spi_wr_data  in  8  SPI write byte.
- spi_we  in  1  SPI write enable (0 = read).
- spi_enable  in  1  SPI request, level, held until spi_ack.
- spi_rd_data  out  8  read data to SPI.
- spi_ack  out  1  SPI transaction complete, 1-cycle pulse.
- spi_idle  out  1  SPI may issue a request.
- user_addr  in  ADDR_BITS  user request address.
- user_wr_data  in  8  user write byte.
- user_we  in  1  user write enable.
- user_enable  in  1  user request, level, held until user_ack.
- user_rd_data  out  8  read data to user.
- user_ack  out  1  user transaction complete, 1-cycle pulse.
- user_idle  out  1  user may issue a request.
- sd_addr  out  ADDR_BITS  address to SDRAM controller.
- sd_wr_data  out  8  write byte to controller.
- sd_we  out  1  write enable to controller.
- sd_enable  out  1  request to controller.
- sd_rd_data  in  8  read data from controller.
- sd_ack  in  1  controller completion pulse.
- sd_idle  in  1  controller ready for a new request.
- timeout_err  out  1  1-cycle pulse when the watchdog aborts a grant.

Behaviour:
- Reset: all registered outputs go to 0; state goes to IDLE; counters clear. Reset mid-transaction drops sd_enable on the next edge without waiting for ack.
- States: IDLE, BUSY_SPI, BUSY_USER, RELEASE.
- IDLE:
  - If sd_idle and spi_enable: latch spi_addr/wr_data/we into the sd_* registers, set sd_enable=1, go to BUSY_SPI.
  - Else if sd_idle and user_enable: same with user_* inputs, go to BUSY_USER.
  - Grant latency is 1 cycle: request sampled at edge N, sd_enable high after edge N+1.
  - Simultaneous requests: SPI wins. User stays pending, with user_enable still held.
- BUSY_x:
  - sd_* stay stable.
  - x_ack = sd_ack while in BUSY_x (combinational, zero added latency).
  - x_rd_data = sd_rd_data in all states (shared wire); valid only when x_ack is high.
  - When sd_ack is seen: sd_enable<=0, sd_we<=0, go to RELEASE.
  - The other requester's ack is always 0.
- RELEASE:
  - Wait until the previous owner's enable is low and sd_idle is high, then go to IDLE.
  - This prevents re-granting a stale enable.
- Watchdog:
  - A counter increments each cycle in BUSY_x and clears on every grant.
  - At TIMEOUT_CYCLES-1 without sd_ack: pulse timeout_err, drop sd_enable, go to RELEASE.
  - No ack is issued to the owner on timeout.
- Idle outputs:
  - spi_idle = (state==IDLE) && sd_idle.
  - user_idle = (state==IDLE) && sd_idle && !spi_enable.
- sd_ack arriving in IDLE or RELEASE is ignored and is not forwarded.
- Only one sd_enable per grant; the arbiter never issues back-to-back without passing through RELEASE.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - An 8-bit counter increments on each SPI grant made while user_enable is high.
  - It clears on each user grant, and when user_enable is low at the SPI grant.
  - When the counter equals STARVE_LIMIT, the next IDLE grant goes to user even if spi_enable is high.
  - user_idle ignores spi_enable while the counter equals STARVE_LIMIT.
- Without the macro: strict SPI priority, and the counter logic is absent.

Test Plan:
- User read, addr 0x00001234, SPI quiet; controller acks 5 cycles after sd_enable with rd_data 0xA5 -> sd_addr=0x1234, sd_we=0; user_ack 1 cycle with user_rd_data 0xA5; spi_ack stays 0.
- Both enables rise same cycle (SPI read 0x10, user write 0x20 data 0x5A) -> SPI granted first. The user write (sd_we=1, sd_wr_data=0x5A, sd_addr=0x20) is issued only after SPI ack and SPI enable drop.
- Owner holds enable 3 cycles after ack -> arbiter stays in RELEASE with no second sd_enable; grants next request 1 cycle after return to IDLE.
- Controller never acks, TIMEOUT_CYCLES=16 -> timeout_err pulse exactly 16 cycles after sd_enable rises; sd_enable drops; no x_ack.
- Reset asserted while BUSY_USER -> next edge sd_enable=0, all acks 0, state IDLE; a subsequent SPI request is granted normally.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=8: SPI requests continuously and user pending -> 8 SPI grants, then 1 user grant, then SPI resumes.
